// File: rtl/dual_update.sv
// ADMM dual-variable update: y <= sat(y + u - z), g <= sat(g + x - v), one element per READ_LATENCY+2 cycles.
// Defining DUAL_UPDATE_RESID_EN adds primal/dual residual maxima tracking for the convergence check.
module dual_update #(
    parameter int STATE_DIM    = 12,
    parameter int INPUT_DIM    = 4,
    parameter int HORIZON      = 30,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [31:0]                  active_horizon,
    output logic [ADDR_WIDTH-1:0]        u_rdaddress,
    output logic [ADDR_WIDTH-1:0]        z_rdaddress,
    output logic [ADDR_WIDTH-1:0]        z_prev_rdaddress,
    output logic [ADDR_WIDTH-1:0]        y_rdaddress,
    input  logic signed [DATA_WIDTH-1:0] u_data_out,
    input  logic signed [DATA_WIDTH-1:0] z_data_out,
    input  logic signed [DATA_WIDTH-1:0] z_prev_data_out,
    input  logic signed [DATA_WIDTH-1:0] y_data_out,
    output logic [ADDR_WIDTH-1:0]        x_rdaddress,
    output logic [ADDR_WIDTH-1:0]        v_rdaddress,
    output logic [ADDR_WIDTH-1:0]        g_rdaddress,
    input  logic signed [DATA_WIDTH-1:0] x_data_out,
    input  logic signed [DATA_WIDTH-1:0] v_data_out,
    input  logic signed [DATA_WIDTH-1:0] g_data_out,
    output logic [ADDR_WIDTH-1:0]        y_wraddress,
    output logic signed [DATA_WIDTH-1:0] y_data_in,
    output logic                         y_wren,
    output logic [ADDR_WIDTH-1:0]        g_wraddress,
    output logic signed [DATA_WIDTH-1:0] g_data_in,
    output logic                         g_wren,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic signed [DATA_WIDTH-1:0] prim_resid,
    output logic signed [DATA_WIDTH-1:0] dual_resid
);
    localparam int E     = READ_LATENCY + 2;
    localparam int PH_W  = $clog2(E);
    localparam int CNT_W = (ADDR_WIDTH > 16) ? ADDR_WIDTH : 16;
    localparam int WW    = DATA_WIDTH + 2;
    localparam logic signed [WW-1:0] SAT_HI = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_LO = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, UPD_Y, UPD_G, DONE} state_t;
    state_t state, state_nx;

    logic [PH_W-1:0]       phase;
    logic [CNT_W-1:0]      idx, y_last, g_last, h_in;
    logic                  h_bad, h_one, last_elem, launch;
    logic                  y_vld_p0, g_vld_p0, y_vld_p1, g_vld_p1;
    logic [ADDR_WIDTH-1:0] in_addr, st_addr, y_addr_p1, g_addr_p1;
    logic signed [DATA_WIDTH-1:0] y_res_p1, g_res_p1;

    function automatic logic signed [WW-1:0] ext(input logic signed [DATA_WIDTH-1:0] a);
        return {{2{a[DATA_WIDTH-1]}}, a};
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [WW-1:0] v);
        if (v > SAT_HI)
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (v < SAT_LO)
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return v[DATA_WIDTH-1:0];
    endfunction

    assign h_in      = active_horizon[CNT_W-1:0];
    assign h_bad     = (active_horizon == 32'd0) || (active_horizon > 32'(HORIZON));
    assign h_one     = (active_horizon == 32'd1);
    assign launch    = (state == IDLE) && start;
    assign last_elem = (phase == PH_W'(E-1)) && (idx == ((state == UPD_Y) ? y_last : g_last));
    assign y_vld_p0  = (state == UPD_Y) && (phase == PH_W'(READ_LATENCY));
    assign g_vld_p0  = (state == UPD_G) && (phase == PH_W'(READ_LATENCY));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = h_bad ? DONE : (h_one ? UPD_G : UPD_Y);
            UPD_Y:   if (last_elem) state_nx = UPD_G;
            UPD_G:   if (last_elem) state_nx = DONE;
            DONE:    if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == UPD_Y) || (state == UPD_G);
        done    = (state == DONE);
        in_addr = (state == UPD_Y) ? idx[ADDR_WIDTH-1:0] : '0;
        st_addr = (state == UPD_G) ? idx[ADDR_WIDTH-1:0] : '0;
    end

    // Element sequencer: phase walks 0..E-1, idx is the linear element index k*DIM + i
    always_ff @(posedge clk) begin
        if (rst || !((state == UPD_Y) || (state == UPD_G))) begin
            phase <= '0;
            idx   <= '0;
        end else if (phase == PH_W'(E-1)) begin
            phase <= '0;
            idx   <= last_elem ? '0 : idx + CNT_W'(1);
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            y_last <= CNT_W'(INPUT_DIM) * (h_in - CNT_W'(1)) - CNT_W'(1);
            g_last <= CNT_W'(STATE_DIM) * h_in - CNT_W'(1);
        end
    end

    // Capture stage p0 -> write stage p1
    always_ff @(posedge clk) begin
        if (rst) begin
            y_vld_p1  <= 1'b0;
            g_vld_p1  <= 1'b0;
            y_addr_p1 <= '0;
            g_addr_p1 <= '0;
            y_res_p1  <= '0;
            g_res_p1  <= '0;
            err       <= 1'b0;
        end else begin
            y_vld_p1 <= y_vld_p0;
            g_vld_p1 <= g_vld_p0;
            if (y_vld_p0) begin
                y_addr_p1 <= idx[ADDR_WIDTH-1:0];
                y_res_p1  <= sat(ext(y_data_out) + ext(u_data_out) - ext(z_data_out));
            end
            if (g_vld_p0) begin
                g_addr_p1 <= idx[ADDR_WIDTH-1:0];
                g_res_p1  <= sat(ext(g_data_out) + ext(x_data_out) - ext(v_data_out));
            end
            if (launch)
                err <= h_bad;
        end
    end

    assign u_rdaddress = in_addr;
    assign z_rdaddress = in_addr;
    assign y_rdaddress = in_addr;
    assign x_rdaddress = st_addr;
    assign v_rdaddress = st_addr;
    assign g_rdaddress = st_addr;
    assign y_wraddress = y_addr_p1;
    assign y_data_in   = y_res_p1;
    assign y_wren      = y_vld_p1;
    assign g_wraddress = g_addr_p1;
    assign g_data_in   = g_res_p1;
    assign g_wren      = g_vld_p1;

`ifdef DUAL_UPDATE_RESID_EN
    logic signed [DATA_WIDTH-1:0] prim_r, dual_r, d_uz, d_zz, d_xv;

    function automatic logic signed [DATA_WIDTH-1:0] abs_diff(input logic signed [DATA_WIDTH-1:0] a,
                                                              input logic signed [DATA_WIDTH-1:0] b);
        logic signed [WW-1:0] d;
        d = ext(a) - ext(b);
        if (d < 0)
            d = -d;
        return sat(d);
    endfunction

    assign d_uz = abs_diff(u_data_out, z_data_out);
    assign d_zz = abs_diff(z_data_out, z_prev_data_out);
    assign d_xv = abs_diff(x_data_out, v_data_out);

    // Residual maxima update alongside the capture stage and hold once the run ends
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            prim_r <= '0;
            dual_r <= '0;
        end else begin
            if (y_vld_p0) begin
                if (d_uz > prim_r) prim_r <= d_uz;
                if (d_zz > dual_r) dual_r <= d_zz;
            end
            if (g_vld_p0 && (d_xv > prim_r))
                prim_r <= d_xv;
        end
    end

    assign z_prev_rdaddress = in_addr;
    assign prim_resid       = prim_r;
    assign dual_resid       = dual_r;
`else
    logic unused_zp;
    assign unused_zp        = ^z_prev_data_out;
    assign z_prev_rdaddress = '0;
    assign prim_resid       = '0;
    assign dual_resid       = '0;
`endif
endmodule

// File: tb/tb_dual_update.sv
// Randomized and directed bench for dual_update against a behavioural trajectory model.
`timescale 1ns/1ps
module tb_dual_update;
    localparam int NX = 12, NU = 4, HZ = 30, DW = 32, AW = 9, RL = 2, E = RL + 2, MEM = 512;

    logic clk = 1'b0;
    logic rst, start;
    logic [31:0] active_horizon;
    logic [AW-1:0] u_ra, z_ra, zp_ra, y_ra, x_ra, v_ra, g_ra, y_wa, g_wa;
    logic [DW-1:0] u_do, z_do, zp_do, y_do, x_do, v_do, g_do, y_di, g_di, prim, dual;
    logic y_we, g_we, busy, done, err;

    dual_update #(.STATE_DIM(NX), .INPUT_DIM(NU), .HORIZON(HZ), .DATA_WIDTH(DW),
                  .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .start(start), .active_horizon(active_horizon),
        .u_rdaddress(u_ra), .z_rdaddress(z_ra), .z_prev_rdaddress(zp_ra), .y_rdaddress(y_ra),
        .u_data_out(u_do), .z_data_out(z_do), .z_prev_data_out(zp_do), .y_data_out(y_do),
        .x_rdaddress(x_ra), .v_rdaddress(v_ra), .g_rdaddress(g_ra),
        .x_data_out(x_do), .v_data_out(v_do), .g_data_out(g_do),
        .y_wraddress(y_wa), .y_data_in(y_di), .y_wren(y_we),
        .g_wraddress(g_wa), .g_data_in(g_di), .g_wren(g_we),
        .busy(busy), .done(done), .err(err), .prim_resid(prim), .dual_resid(dual));

    always #5 clk = ~clk;

    int mu[MEM], mz[MEM], mzp[MEM], my[MEM], mx[MEM], mv[MEM], mg[MEM];
    int ey[MEM], eg[MEM];
    int ep, ed, ny, ng;
    int n_cmp = 0, n_bad = 0;

    typedef struct { int addr; int data; } wr_t;
    wr_t yq[$], gq[$];

    // RAM model: data_out reflects the address presented READ_LATENCY cycles earlier
    logic [AW-1:0] ra[7];
    logic [AW-1:0] pipe[7][RL];
    assign ra[0] = u_ra; assign ra[1] = z_ra; assign ra[2] = zp_ra; assign ra[3] = y_ra;
    assign ra[4] = x_ra; assign ra[5] = v_ra; assign ra[6] = g_ra;
    assign u_do  = mu[pipe[0][RL-1]];
    assign z_do  = mz[pipe[1][RL-1]];
    assign zp_do = mzp[pipe[2][RL-1]];
    assign y_do  = my[pipe[3][RL-1]];
    assign x_do  = mx[pipe[4][RL-1]];
    assign v_do  = mv[pipe[5][RL-1]];
    assign g_do  = mg[pipe[6][RL-1]];

    always @(posedge clk) begin
        for (int m = 0; m < 7; m++) begin
            pipe[m][0] <= ra[m];
            for (int j = 1; j < RL; j++) pipe[m][j] <= pipe[m][j-1];
        end
    end

    always @(posedge clk) begin
        if (y_we) my[y_wa] = int'(y_di);
        if (g_we) mg[g_wa] = int'(g_di);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input longint s);
        if (s > 64'sd2147483647) return 32'sh7FFFFFFF;
        if (s < -64'sd2147483648) return 32'sh80000000;
        return int'(s);
    endfunction

    function automatic int sat_abs(input int a, input int b);
        longint d;
        d = longint'(a) - longint'(b);
        if (d < 0) d = -d;
        return sat(d);
    endfunction

    always @(negedge clk) begin : cmp
        wr_t e;
        if (y_we || g_we) begin
            chk("wren_exclusive", longint'(y_we && g_we), 0);
            chk("wren_while_busy", longint'(busy), 1);
        end
        if (y_we) begin
            ny++;
            if (yq.size() == 0) chk("y_unexpected_write_addr", longint'(y_wa), -1);
            else begin
                e = yq.pop_front();
                chk("y_wraddress", longint'(y_wa), e.addr);
                chk("y_data_in", longint'($signed(y_di)), e.data);
            end
        end
        if (g_we) begin
            ng++;
            if (gq.size() == 0) chk("g_unexpected_write_addr", longint'(g_wa), -1);
            else begin
                e = gq.pop_front();
                chk("g_wraddress", longint'(g_wa), e.addr);
                chk("g_data_in", longint'($signed(g_di)), e.data);
            end
        end
    end

    // Reference: walk the trajectories in k-major, i-minor order from the current RAM contents
    task automatic build(input int h);
        yq.delete(); gq.delete();
        ep = 0; ed = 0;
        ey = my; eg = mg;
        if (h < 1 || h > HZ) return;
        for (int k = 0; k < h - 1; k++)
            for (int i = 0; i < NU; i++) begin
                int a = k * NU + i;
                ey[a] = sat(longint'(my[a]) + longint'(mu[a]) - longint'(mz[a]));
                yq.push_back('{a, ey[a]});
                if (sat_abs(mu[a], mz[a]) > ep) ep = sat_abs(mu[a], mz[a]);
                if (sat_abs(mz[a], mzp[a]) > ed) ed = sat_abs(mz[a], mzp[a]);
            end
        for (int k = 0; k < h; k++)
            for (int i = 0; i < NX; i++) begin
                int a = k * NX + i;
                eg[a] = sat(longint'(mg[a]) + longint'(mx[a]) - longint'(mv[a]));
                gq.push_back('{a, eg[a]});
                if (sat_abs(mx[a], mv[a]) > ep) ep = sat_abs(mx[a], mv[a]);
            end
    endtask

    task automatic run(input logic [31:0] h, output int dedge);
        int hh, limit, expd, bad_y, bad_g;
        logic bad;
        hh = int'(h);
        bad = (hh < 1) || (hh > HZ);
        expd = bad ? 2 : 1 + E * (NU * (hh - 1) + NX * hh);
        limit = expd + 50;
        build(hh);
        ny = 0; ng = 0;
        @(negedge clk);
        active_horizon = h;
        start = 1'b1;
        dedge = 0;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if (done) begin dedge = n; break; end
        end
        if (dedge == 0) chk("done_timeout", 0, 1);
        else if (bad) chk("err_done_within_2", longint'(dedge <= 2), 1);
        else chk("done_edge", dedge, expd);
        chk("err_flag", longint'(err), longint'(bad));
`ifdef DUAL_UPDATE_RESID_EN
        chk("prim_resid", longint'($signed(prim)), ep);
        chk("dual_resid", longint'($signed(dual)), ed);
`else
        chk("prim_resid_tied", longint'(prim), 0);
        chk("dual_resid_tied", longint'(dual), 0);
`endif
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (!done) break;
        end
        chk("done_released", longint'(done), 0);
        chk("err_held", longint'(err), longint'(bad));
        chk("y_writes_missing", yq.size(), 0);
        chk("g_writes_missing", gq.size(), 0);
        bad_y = 0; bad_g = 0;
        for (int a = 0; a < MEM; a++) begin
            if (my[a] != ey[a]) bad_y++;
            if (mg[a] != eg[a]) bad_g++;
        end
        chk("y_ram_words_wrong", bad_y, 0);
        chk("g_ram_words_wrong", bad_g, 0);
    endtask

    task automatic fill(input int yv, input int uv, input int zv, input int zpv,
                        input int gv, input int xv, input int vv);
        for (int a = 0; a < MEM; a++) begin
            my[a] = yv; mu[a] = uv; mz[a] = zv; mzp[a] = zpv;
            mg[a] = gv; mx[a] = xv; mv[a] = vv;
        end
    endtask

    function automatic int rnd_val();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int de;
        rst = 1'b1; start = 1'b0; active_horizon = '0;
        fill(0, 0, 0, 0, 0, 0, 0);
        ny = 0; ng = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", longint'({u_ra, z_ra, zp_ra, y_ra, x_ra, v_ra, g_ra, y_wa, y_di, y_we,
                                            g_wa, g_di, g_we, busy, done, err, prim, dual} != '0), 0);
        @(negedge clk);
        rst = 1'b0;

        fill(5, 3, 1, 0, -1, 10, 12);
        run(2, de);
        chk("lit_done_at_113", de, 113);
        chk("lit_y3_is_7", my[3], 7);
        chk("lit_y4_untouched", my[4], 5);
        chk("lit_g23_is_m3", mg[23], -3);
        chk("lit_g24_untouched", mg[24], -1);

        my[0] = 32'h7FFFFFF0; mu[0] = 32'h20; mz[0] = 0;
        my[1] = 32'h80000010; mu[1] = 0;      mz[1] = 32'h20;
        run(2, de);
        chk("lit_sat_hi", my[0], 32'sh7FFFFFFF);
        chk("lit_sat_lo", my[1], 32'sh80000000);

        run(32'd0, de);
        chk("lit_h0_no_writes", ny + ng, 0);
        run(32'd31, de);
        chk("lit_h31_no_writes", ny + ng, 0);
        run(32'hFFFF_FFFF, de);

        fill(1, 2, 3, 4, 5, 6, 7);
        run(32'd1, de);
        chk("lit_h1_y_pulses", ny, 0);
        chk("lit_h1_g_pulses", ng, 12);

        // Reset in the middle of UPD_G, then a clean run
        fill(2, 1, 1, 0, 3, 4, 2);
        build(2);
        ng = 0;
        @(negedge clk);
        active_horizon = 32'd2; start = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (ng >= 5) break;
        end
        chk("reached_g_element_5", longint'(ng >= 5), 1);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("midrun_reset_outputs_zero", longint'({u_ra, z_ra, zp_ra, y_ra, x_ra, v_ra, g_ra, y_wa, y_di, y_we,
                                                   g_wa, g_di, g_we, busy, done, err, prim, dual} != '0), 0);
        @(negedge clk);
        rst = 1'b0;
        yq.delete(); gq.delete();
        run(2, de);

        fill(0, 0, 0, 0, 0, 0, 0);
        mu[2] = -9;
        mz[1] = 4; mu[1] = 4;
        mx[7] = 6;
        run(2, de);
`ifdef DUAL_UPDATE_RESID_EN
        chk("lit_prim_resid_9", longint'($signed(prim)), 9);
        chk("lit_dual_resid_4", longint'($signed(dual)), 4);
`else
        chk("lit_prim_resid_off", longint'(prim), 0);
`endif

        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < MEM; a++) begin
                my[a] = rnd_val(); mu[a] = rnd_val(); mz[a] = rnd_val(); mzp[a] = rnd_val();
                mg[a] = rnd_val(); mx[a] = rnd_val(); mv[a] = rnd_val();
            end
            run(32'($urandom_range(1, HZ)), de);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
